// File: rtl/mem_pkg.sv
// mem_pkg -- command/state encodings and MMIO address defaults shared with the CPU.
// Rev 1.0
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } mem_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } resp_state_e;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  function automatic logic is_op(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ram_sp.sv
// mem_ram_sp -- single-port RAM, synchronous write, combinational read.
// Rev 1.0
`default_nettype none

module mem_ram_sp #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder -- memory-side responder: RAM plus LED/switch MMIO with fixed read latency.
// Rev 1.0
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 256,
  parameter int                RD_LAT   = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  output logic              cmd_err
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]        CNT_INIT  = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  resp_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  mem_cmd_e          cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        led_q;
  logic              err_q;
  logic [7:0]        sw_meta_q, sw_sync_q;

  logic              can_accept;
  logic              accept;
  logic              err_set;
  logic              commit;
  mem_cmd_e          op_cmd;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_in_ram;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_mux;

  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept     = can_accept && is_op(mem_cmd);
  assign err_set    = (can_accept && (mem_cmd == CMD_RSVD)) ||
                      ((state_q == ST_WAIT) && (mem_cmd != CMD_NONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      cmd_d   = mem_cmd_e'(mem_cmd);
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      cnt_d   = CNT_INIT;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (RD_LAT == 1) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_DONE: begin
        if (accept) state_d = (RD_LAT == 1) ? ST_DONE : ST_WAIT;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With RD_LAT=1 the op completes on the same edge it is accepted, so use the
  // incoming request rather than the not-yet-latched copy.
  assign op_cmd    = (RD_LAT == 1) ? cmd_d   : cmd_q;
  assign op_addr   = (RD_LAT == 1) ? addr_d  : addr_q;
  assign op_wdata  = (RD_LAT == 1) ? wdata_d : wdata_q;
  assign commit    = (state_d == ST_DONE);
  assign op_in_ram = ({1'b0, op_addr} < DEPTH_EXT);
  assign ram_we    = commit && !reset && (op_cmd == CMD_WRITE) && op_in_ram;

  mem_ram_sp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (op_addr[AW-1:0]),
    .wdata_i (op_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rd_mux = '0;
    if (op_in_ram)                rd_mux = ram_rdata;
    else if (op_addr == LED_ADDR) rd_mux = {{(DATA_W-8){1'b0}}, led_q};
    else if (op_addr == SW_ADDR)  rd_mux = {{(DATA_W-8){1'b0}}, sw_sync_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      cmd_q     <= CMD_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      led_q     <= 8'h00;
      err_q     <= 1'b0;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      if (err_set) err_q <= 1'b1;
      if (commit) begin
        if ((op_cmd == CMD_WRITE) && !op_in_ram && (op_addr == LED_ADDR)) begin
          led_q <= op_wdata[7:0];
        end
        if (op_cmd == CMD_READ) begin
          rdata_q <= rd_mux;
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == ST_DONE);
  assign led_out   = led_q;
  assign cmd_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed checks of mem_responder at RD_LAT=1 (vector table) and RD_LAT=3.
// Rev 1.0
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3;
  logic [1:0]  cmd1, cmd3;
  logic [8:0]  addr1, addr3;
  logic [15:0] wdata1, wdata3;
  logic [15:0] rdata1, rdata3;
  logic        ready1, ready3;
  logic [7:0]  sw1, sw3;
  logic [7:0]  led1, led3;
  logic        err1, err3;

  int checks = 0;
  int errors = 0;

  mem_responder #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .mem_cmd(cmd1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(rdata1), .mem_ready(ready1), .sw_in(sw1), .led_out(led1), .cmd_err(err1)
  );

  mem_responder #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst3), .mem_cmd(cmd3), .mem_addr(addr3), .mem_wdata(wdata3),
    .mem_rdata(rdata3), .mem_ready(ready3), .sw_in(sw3), .led_out(led3), .cmd_err(err3)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  sw;
    logic        ready;
    logic [15:0] rdata;
    logic [7:0]  led;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                              input logic [7:0] s, input logic r, input logic [15:0] rd,
                              input logic [7:0] l, input logic e);
    vec_t v;
    v.cmd = c; v.addr = a; v.wdata = d; v.sw = s;
    v.ready = r; v.rdata = rd; v.led = l; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmd3 = 2'b00;
  endtask

  task automatic drive3(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    cmd3 = c; addr3 = a; wdata3 = d;
  endtask

  // Issue one op on the RD_LAT=3 DUT and follow it to its DONE cycle.
  task automatic op3(input string name, input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] d, input logic chk_rd, input logic [15:0] exp_rd);
    drive3(c, a, d);
    tick(); chk({name, " ready T+1"}, 32'(ready3), 32'd0);
    tick(); chk({name, " ready T+2"}, 32'(ready3), 32'd0);
    tick(); chk({name, " ready T+3"}, 32'(ready3), 32'd1);
    if (chk_rd) chk({name, " rdata"}, 32'(rdata3), 32'(exp_rd));
  endtask

  localparam logic [1:0] N = 2'b00, R = 2'b01, W = 2'b10, X = 2'b11;

  logic [1:0]  b2b_cmd  [5];
  logic [8:0]  b2b_addr [5];
  logic [15:0] b2b_data [5];
  int          pulses;

  initial begin
    // Each entry: inputs applied this cycle, and outputs expected in this same cycle.
    vecs[0]  = mk(W, 9'h005, 16'hBEEF, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
    vecs[1]  = mk(R, 9'h005, 16'h0000, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b0);
    vecs[2]  = mk(W, 9'h100, 16'h12A5, 8'h00, 1'b1, 16'hBEEF, 8'h00, 1'b0);
    vecs[3]  = mk(R, 9'h100, 16'h0000, 8'h00, 1'b1, 16'hBEEF, 8'hA5, 1'b0);
    vecs[4]  = mk(N, 9'h000, 16'h0000, 8'h3C, 1'b1, 16'h00A5, 8'hA5, 1'b0);
    vecs[5]  = mk(N, 9'h000, 16'h0000, 8'h3C, 1'b0, 16'h00A5, 8'hA5, 1'b0);
    vecs[6]  = mk(R, 9'h140, 16'h0000, 8'h3C, 1'b0, 16'h00A5, 8'hA5, 1'b0);
    vecs[7]  = mk(W, 9'h140, 16'hFFFF, 8'h3C, 1'b1, 16'h003C, 8'hA5, 1'b0);
    vecs[8]  = mk(R, 9'h140, 16'h0000, 8'h3C, 1'b1, 16'h003C, 8'hA5, 1'b0);
    vecs[9]  = mk(W, 9'h0FF, 16'h0001, 8'h3C, 1'b1, 16'h003C, 8'hA5, 1'b0);
    vecs[10] = mk(R, 9'h0FF, 16'h0000, 8'h3C, 1'b1, 16'h003C, 8'hA5, 1'b0);
    vecs[11] = mk(R, 9'h1F0, 16'h0000, 8'h3C, 1'b1, 16'h0001, 8'hA5, 1'b0);
    vecs[12] = mk(X, 9'h005, 16'h9999, 8'h3C, 1'b1, 16'h0000, 8'hA5, 1'b0);
    vecs[13] = mk(N, 9'h000, 16'h0000, 8'h3C, 1'b0, 16'h0000, 8'hA5, 1'b1);
    vecs[14] = mk(R, 9'h005, 16'h0000, 8'h3C, 1'b0, 16'h0000, 8'hA5, 1'b1);
    vecs[15] = mk(N, 9'h000, 16'h0000, 8'h3C, 1'b1, 16'hBEEF, 8'hA5, 1'b1);
    vecs[16] = mk(N, 9'h000, 16'h0000, 8'h3C, 1'b0, 16'hBEEF, 8'hA5, 1'b1);

    b2b_cmd[0] = W; b2b_addr[0] = 9'h030; b2b_data[0] = 16'h1111;
    b2b_cmd[1] = R; b2b_addr[1] = 9'h030; b2b_data[1] = 16'h1111;
    b2b_cmd[2] = W; b2b_addr[2] = 9'h031; b2b_data[2] = 16'h2222;
    b2b_cmd[3] = R; b2b_addr[3] = 9'h031; b2b_data[3] = 16'h2222;
    b2b_cmd[4] = W; b2b_addr[4] = 9'h030; b2b_data[4] = 16'h3333;

    rst1 = 1'b1; rst3 = 1'b1;
    cmd1 = N; addr1 = '0; wdata1 = '0; sw1 = 8'h00;
    cmd3 = N; addr3 = '0; wdata3 = '0; sw3 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst3 = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("v%0d ready", i), 32'(ready1), 32'(vecs[i].ready));
      chk($sformatf("v%0d rdata", i), 32'(rdata1), 32'(vecs[i].rdata));
      chk($sformatf("v%0d led", i),   32'(led1),   32'(vecs[i].led));
      chk($sformatf("v%0d err", i),   32'(err1),   32'(vecs[i].err));
      cmd1 = vecs[i].cmd; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata; sw1 = vecs[i].sw;
    end

    // RD_LAT=3: LED write, write then read-after-write from the DONE cycle.
    chk("l3 reset ready", 32'(ready3), 32'd0);
    op3("l3 led wr", W, 9'h100, 16'h00FF, 1'b0, 16'h0000);
    chk("l3 led", 32'(led3), 32'h0000_00FF);
    tick();
    op3("l3 wr020", W, 9'h020, 16'h1234, 1'b0, 16'h0000);
    op3("l3 raw020", R, 9'h020, 16'h0000, 1'b1, 16'h1234);
    tick();

    // Command during WAIT is dropped and flags an error.
    drive3(R, 9'h020, 16'h0000);
    tick(); chk("l3 lat T1 ready", 32'(ready3), 32'd0);
    drive3(W, 9'h020, 16'h5555);
    tick(); chk("l3 lat T2 ready", 32'(ready3), 32'd0);
    chk("l3 wait err", 32'(err3), 32'd1);
    tick(); chk("l3 lat T3 ready", 32'(ready3), 32'd1);
    chk("l3 lat rdata", 32'(rdata3), 32'h0000_1234);
    op3("l3 ram intact", R, 9'h020, 16'h0000, 1'b1, 16'h1234);

    // Five ops chained, each issued in the previous op's DONE cycle.
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drive3(b2b_cmd[k], b2b_addr[k], b2b_data[k]);
      for (int t = 1; t <= 3; t++) begin
        tick();
        pulses += int'(ready3);
      end
      chk($sformatf("b2b%0d ready", k), 32'(ready3), 32'd1);
      if (b2b_cmd[k] == R) chk($sformatf("b2b%0d rdata", k), 32'(rdata3), 32'(b2b_data[k]));
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      pulses += int'(ready3);
    end
    chk("b2b pulse count", 32'(pulses), 32'd5);
    op3("b2b final rd", R, 9'h030, 16'h0000, 1'b1, 16'h3333);
    tick();

    // Reset in the middle of a write aborts it.
    op3("rst prep", W, 9'h010, 16'h0AAA, 1'b0, 16'h0000);
    tick();
    drive3(W, 9'h010, 16'h7777);
    tick();
    rst3 = 1'b1;
    chk("rst T1 ready", 32'(ready3), 32'd0);
    tick();
    rst3 = 1'b0;
    chk("rst T2 ready", 32'(ready3), 32'd0);
    chk("rst rdata", 32'(rdata3), 32'd0);
    chk("rst led", 32'(led3), 32'd0);
    chk("rst err", 32'(err3), 32'd0);
    tick(); chk("rst T3 ready", 32'(ready3), 32'd0);
    tick(); chk("rst T4 ready", 32'(ready3), 32'd0);
    op3("rst old data", R, 9'h010, 16'h0000, 1'b1, 16'h0AAA);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU memory interface: accepts a 2-bit memory command, 9-bit address and 16-bit write data, and returns 16-bit read data plus a completion strobe.
- Backs a single-port data/instruction RAM and two memory-mapped I/O registers: an LED output register and a synchronised switch input.
- Sits beside the CPU top at the board-level wrapper; the CPU is the initiator, this block is the responder.

Parameters:
- ADDR_W, 9, address width (matches the CPU PC/address width)
- DATA_W, 16, data word width
- DEPTH, 256, RAM words, mapped at addresses 0..DEPTH-1
- RD_LAT, 1, cycles from request to mem_ready; legal range 1..4
- LED_ADDR, 9'h100, address of the LED output register
- SW_ADDR, 9'h140, address of the switch input

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_cmd  in  2  command: NONE=00, READ=01, WRITE=10, 11 reserved
- mem_addr  in  ADDR_W  request address, sampled with mem_cmd
- mem_wdata  in  DATA_W  write data, sampled with mem_cmd
- mem_rdata  out  DATA_W  read data, valid when mem_ready=1, then held
- mem_ready  out  1  one-cycle completion pulse for READ and WRITE
- sw_in  in  8  asynchronous board switches
- led_out  out  8  LED register
- cmd_err  out  1  sticky protocol-error flag

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates on the posedge.
- Reset values: state=IDLE, mem_rdata=0, mem_ready=0, led_out=0, cmd_err=0, wait counter=0, switch synchroniser=0. RAM contents are not reset.
- Request: mem_cmd is a single-cycle strobe. A non-NONE command is accepted only in IDLE or DONE. At acceptance, cmd, addr and wdata are latched.
- FSM states:
  - IDLE: accept a command. RD_LAT=1 goes to DONE; otherwise go to WAIT with cnt=RD_LAT-2.
  - WAIT: decrement cnt; go to DONE when cnt==0.
  - DONE: mem_ready=1 for exactly this cycle. A new request accepted in DONE follows the IDLE rules; otherwise return to IDLE.
- Timing:
  - Request sampled in cycle T gives mem_ready=1 in cycle T+RD_LAT.
  - Back-to-back throughput is one operation per RD_LAT cycles.
- Write commit: the write happens on the edge entering DONE, so the target is updated when mem_ready is high.
  - addr<DEPTH: RAM[addr]=wdata.
  - addr==LED_ADDR: led_out=wdata[7:0].
  - Any other address: ignored.
- Read data: mem_rdata is loaded on the edge entering DONE and holds until the next read completes. Writes do not change mem_rdata.
  - addr<DEPTH: RAM[addr].
  - LED_ADDR: {8'h00, led_out}.
  - SW_ADDR: {8'h00, sw_sync}.
  - Otherwise: 16'h0000.
- Switch synchronisation: sw_in passes through a 2-flop synchroniser, so sw_sync lags sw_in by 2 cycles.
- Read-after-write: a READ to the same address accepted in the DONE cycle of a WRITE returns the new data.
- Errors, all of which set cmd_err (sticky, cleared only by reset):
  - Command 11 in IDLE or DONE: no operation, no mem_ready.
  - Any non-NONE command presented in WAIT: dropped, the in-flight operation is unaffected.
- Reset mid-operation: the in-flight operation is aborted, no write is committed unless DONE was already reached, and mem_ready stays 0.
- Address boundary: addr=DEPTH-1 maps to RAM; addr=DEPTH maps to unmapped space.

Decomposition:
- Package mem_pkg:
  - mem_cmd_e enum (NONE, READ, WRITE, RSVD)
  - resp_state_e (IDLE, WAIT, DONE)
  - LED_ADDR and SW_ADDR defaults
  - shared with the CPU for command encoding
- One sub-module, mem_ram_sp: single-port RAM, DEPTH x DATA_W, synchronous write, combinational read feeding the mem_rdata register.

Test Plan:
- Write/read, RD_LAT=1: WRITE addr 9'h005, data 16'hBEEF at T0 -> mem_ready at T1; READ 9'h005 at T1 -> mem_ready at T2 with mem_rdata=16'hBEEF.
- RD_LAT=3 latency: READ at T0 -> mem_ready low at T1 and T2, high only at T3; a WRITE strobed at T1 -> cmd_err=1 and RAM unchanged.
- MMIO:
  - WRITE LED_ADDR data 16'h12A5 -> led_out=8'hA5.
  - READ LED_ADDR -> 16'h00A5.
  - sw_in=8'h3C held 3 cycles, READ SW_ADDR -> 16'h003C.
  - WRITE SW_ADDR -> no effect.
- Boundary/unmapped: WRITE 9'h0FF data 16'h0001 then READ 9'h0FF -> 16'h0001; READ 9'h1F0 -> 16'h0000 with mem_ready pulse; mem_cmd=11 -> no mem_ready and cmd_err=1.
- Reset mid-op (RD_LAT=3): WRITE 9'h010 data 16'h7777 at T0, reset at T1 -> no mem_ready, all outputs 0; READ 9'h010 -> old value, not 16'h7777.
- Back-to-back: five alternating WRITE/READ strobes, each in the DONE cycle of the previous op -> exactly five mem_ready pulses and correct data each time.
